// File: rtl/mux_arb4.sv
// -----------------------------------------------------------------------------
// mux_arb4
//   Four-way round-robin arbiter driving a shared 1-bit data mux.
//   One owner at a time holds the mux output. It keeps ownership until it
//   drops its request, or until it has held for MAX_HOLD consecutive cycles
//   while someone else is waiting. When ownership is handed over, the next
//   grant is issued in the same edge, so there is no idle gap.
//
// Parameters
//   MAX_HOLD   : consecutive cycles an owner may keep the grant while another
//                requester waits (1..15).
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   request    : [0:3] request[i] high = requester i wants the output
//   inputData  : [0:3] inputData[i] = requester i's data bit
//   grant      : [0:3] registered one-hot (or zero) ownership vector
//   selectLine : registered binary index of the current owner
//   outValid   : registered, high while an owner exists
//   muxOutput  : combinational, inputData[selectLine] when outValid else 0
// -----------------------------------------------------------------------------
module mux_arb4 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:3] request,
  input  logic [0:3] inputData,
  output logic [0:3] grant,
  output logic [1:0] selectLine,
  output logic       outValid,
  output logic       muxOutput
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Hold counter value at which the owner has used up its slot.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [0:3] r_grant;
  logic [1:0] r_sel;
  logic       r_valid;
  logic [3:0] r_hold_cnt;
  logic [1:0] r_ptr;

  // Next-state values
  state_t     w_state_next;
  logic [0:3] w_grant_next;
  logic [1:0] w_sel_next;
  logic       w_valid_next;
  logic [3:0] w_hold_cnt_next;
  logic [1:0] w_ptr_next;

  // ---------------------------------------------------------------------------
  // Round-robin search: candidate gi is requester (ptr + gi) mod 4.
  // The 2-bit add wraps naturally, giving the modulo for free.
  // ---------------------------------------------------------------------------
  logic [1:0] w_cand_idx [4];
  logic [3:0] w_cand_req;
  logic [1:0] w_win_idx;
  logic       w_any_req;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand_idx[gi] = r_ptr + 2'(gi);
      assign w_cand_req[gi] = request[w_cand_idx[gi]];
    end
  endgenerate

  // Walk from the farthest candidate back to the nearest so the nearest
  // active candidate (lowest offset from ptr) is the one left standing.
  always_comb begin
    w_win_idx = w_cand_idx[0];
    for (int i = 3; i >= 0; i--) begin
      if (w_cand_req[i]) begin
        w_win_idx = w_cand_idx[i];
      end
    end
  end

  assign w_any_req = |request;

  // ---------------------------------------------------------------------------
  // Ownership status of the current owner
  // ---------------------------------------------------------------------------
  logic w_owner_req;
  logic w_others_req;
  logic w_at_limit;
  logic w_release;

  assign w_owner_req  = request[r_sel];
  // Anyone other than the current owner asking for the output.
  assign w_others_req = |(request & ~r_grant);
  assign w_at_limit   = (r_hold_cnt == HOLD_LAST);
  // Forced release only happens under contention; a lone owner keeps going.
  assign w_release    = !w_owner_req || (w_at_limit && w_others_req);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_sel_next      = r_sel;
    w_valid_next    = r_valid;
    w_hold_cnt_next = r_hold_cnt;
    w_ptr_next      = r_ptr;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next            = ST_BUSY;
          w_grant_next            = '0;
          w_grant_next[w_win_idx] = 1'b1;
          w_sel_next              = w_win_idx;
          w_valid_next            = 1'b1;
          w_hold_cnt_next         = '0;
          w_ptr_next              = w_win_idx + 2'd1;
        end
      end

      ST_BUSY: begin
        if (w_release) begin
          // ptr already points at owner+1, so the search naturally puts the
          // outgoing owner last in line.
          if (w_any_req) begin
            w_state_next            = ST_BUSY;
            w_grant_next            = '0;
            w_grant_next[w_win_idx] = 1'b1;
            w_sel_next              = w_win_idx;
            w_valid_next            = 1'b1;
            w_hold_cnt_next         = '0;
            w_ptr_next              = w_win_idx + 2'd1;
          end else begin
            w_state_next    = ST_IDLE;
            w_grant_next    = '0;
            w_sel_next      = 2'd0;
            w_valid_next    = 1'b0;
            w_hold_cnt_next = '0;
          end
        end else if (w_at_limit) begin
          // Slot used up but nobody waiting: start a fresh slot.
          w_hold_cnt_next = '0;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 4'd1;
        end
      end

      default: begin
        w_state_next    = ST_IDLE;
        w_grant_next    = '0;
        w_sel_next      = 2'd0;
        w_valid_next    = 1'b0;
        w_hold_cnt_next = '0;
        w_ptr_next      = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_sel      <= 2'd0;
      r_valid    <= 1'b0;
      r_hold_cnt <= '0;
      r_ptr      <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_sel      <= w_sel_next;
      r_valid    <= w_valid_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_ptr      <= w_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant      = r_grant;
  assign selectLine = r_sel;
  assign outValid   = r_valid;
  assign muxOutput  = r_valid ? inputData[r_sel] : 1'b0;

endmodule

// File: tb/tb_mux_arb4.sv
// -----------------------------------------------------------------------------
// tb_mux_arb4
//   Table-driven check of mux_arb4 (MAX_HOLD = 4) plus a hand-written sequence
//   on a second instance with MAX_HOLD = 1. Structural invariants of grant /
//   selectLine / outValid are checked on every falling edge for both.
// -----------------------------------------------------------------------------
module tb_mux_arb4;

  logic       clk;
  logic       rst;
  logic [0:3] request;
  logic [0:3] inputData;
  logic [0:3] grant;
  logic [1:0] selectLine;
  logic       outValid;
  logic       muxOutput;

  logic       rst1;
  logic [0:3] req1;
  logic [0:3] data1;
  logic [0:3] grant1;
  logic [1:0] sel1;
  logic       valid1;
  logic       mux1;

  int tests_run;
  int tests_failed;

  mux_arb4 #(.MAX_HOLD(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .request    (request),
    .inputData  (inputData),
    .grant      (grant),
    .selectLine (selectLine),
    .outValid   (outValid),
    .muxOutput  (muxOutput)
  );

  mux_arb4 #(.MAX_HOLD(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst1),
    .request    (req1),
    .inputData  (data1),
    .grant      (grant1),
    .selectLine (sel1),
    .outValid   (valid1),
    .muxOutput  (mux1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Vector table: inputs applied before an edge, outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic [0:3] req;
    logic [0:3] data;
    logic [0:3] exp_grant;
    logic [1:0] exp_sel;
    logic       exp_valid;
    logic       exp_mux;
    string      name;
  } vec_t;

  vec_t vecs[80];
  int   nv;

  // muxOutput follows its definition: data of the selected owner when valid.
  task automatic add(input logic r, input logic [0:3] rq, input logic [0:3] d,
                     input logic [0:3] g, input logic [1:0] s, input logic v,
                     input string nm);
    logic [0:3] dd;
    dd = d;
    vecs[nv].rst       = r;
    vecs[nv].req       = rq;
    vecs[nv].data      = d;
    vecs[nv].exp_grant = g;
    vecs[nv].exp_sel   = s;
    vecs[nv].exp_valid = v;
    vecs[nv].exp_mux   = v ? dd[s] : 1'b0;
    vecs[nv].name      = nm;
    nv++;
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle invariants on both instances
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    tests_run++;
    if (!(($countones(grant) <= 1) && (outValid == (|grant)) &&
          (!outValid || grant[selectLine]))) begin
      tests_failed++;
      $display("FAIL invariant_h4 t=%0t: grant=%b sel=%0d valid=%b, required one-hot grant matching sel/valid",
               $time, grant, selectLine, outValid);
    end
    tests_run++;
    if (!(($countones(grant1) <= 1) && (valid1 == (|grant1)) &&
          (!valid1 || grant1[sel1]))) begin
      tests_failed++;
      $display("FAIL invariant_h1 t=%0t: grant=%b sel=%0d valid=%b, required one-hot grant matching sel/valid",
               $time, grant1, sel1, valid1);
    end
  end

  initial begin
    logic [0:3] g;
    int         owner;

    tests_run    = 0;
    tests_failed = 0;
    nv           = 0;
    rst          = 1'b1;
    request      = '0;
    inputData    = '0;
    rst1         = 1'b1;
    req1         = '0;
    data1        = '0;

    // --- single requester, long hold without contention ---
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    add(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, "reset_priority");
    for (int i = 0; i < 10; i++)
      add(0, 4'b0010, 4'b0010, 4'b0010, 2'd2, 1, "single_hold");
    add(0, 4'b0010, 4'b1101, 4'b0010, 2'd2, 1, "single_data0");
    add(0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0, "to_idle");

    // --- full contention, 4-cycle slots, rotation 0->1->2->3->0 ---
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    for (int i = 0; i < 20; i++) begin
      owner = (i / 4) % 4;
      g = 4'b0000;
      g[owner] = 1'b1;
      add(0, 4'b1111, 4'b1010, g, 2'(owner), 1, "rotate");
    end

    // --- early drop by owner 0, owner 3 takes over with a fresh slot ---
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    add(0, 4'b1001, 4'b0001, 4'b1000, 2'd0, 1, "drop_grant0");
    add(0, 4'b1001, 4'b0001, 4'b1000, 2'd0, 1, "drop_hold0");
    add(0, 4'b0001, 4'b0001, 4'b0001, 2'd3, 1, "drop_move3");
    for (int i = 0; i < 3; i++)
      add(0, 4'b1001, 4'b0001, 4'b0001, 2'd3, 1, "drop_fresh_slot");
    add(0, 4'b1001, 4'b0001, 4'b1000, 2'd0, 1, "drop_slot_end");
    add(0, 4'b0001, 4'b0001, 4'b0001, 2'd3, 1, "owner_drop_other");
    add(0, 4'b1000, 4'b1000, 4'b1000, 2'd0, 1, "owner_drop_lone");
    add(0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0, "to_idle");

    // --- reset mid-burst, then arbitration restarts from ptr 0 ---
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    add(0, 4'b0010, 4'b0101, 4'b0010, 2'd2, 1, "burst_grant2");
    add(0, 4'b0111, 4'b0101, 4'b0010, 2'd2, 1, "burst_hold2");
    add(1, 4'b0111, 4'b0101, 4'b0000, 2'd0, 0, "burst_reset");
    add(0, 4'b0111, 4'b0101, 4'b0100, 2'd1, 1, "burst_regrant1");

    for (int i = 0; i < nv; i++) begin
      rst       = vecs[i].rst;
      request   = vecs[i].req;
      inputData = vecs[i].data;
      @(posedge clk);
      #1;
      tests_run++;
      if (grant !== vecs[i].exp_grant || selectLine !== vecs[i].exp_sel ||
          outValid !== vecs[i].exp_valid || muxOutput !== vecs[i].exp_mux) begin
        tests_failed++;
        $display("FAIL vec%0d %s: got grant=%b sel=%0d valid=%b mux=%b, required grant=%b sel=%0d valid=%b mux=%b",
                 i, vecs[i].name, grant, selectLine, outValid, muxOutput,
                 vecs[i].exp_grant, vecs[i].exp_sel, vecs[i].exp_valid, vecs[i].exp_mux);
      end else begin
        $display("[TB] vec%0d %s req=%b grant=%b sel=%0d ok", i, vecs[i].name,
                 vecs[i].req, grant, selectLine);
      end
    end

    // --- MAX_HOLD = 1: rotate every cycle under contention ---
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (grant1 !== 4'b0000 || valid1 !== 1'b0 || sel1 !== 2'd0 || mux1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL h1_reset: got grant=%b sel=%0d valid=%b mux=%b, required all zero",
               grant1, sel1, valid1, mux1);
    end
    rst1  = 1'b0;
    req1  = 4'b1110;
    data1 = 4'b1010;
    for (int i = 0; i < 9; i++) begin
      owner = i % 3;
      g = 4'b0000;
      g[owner] = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (grant1 !== g || sel1 !== 2'(owner) || valid1 !== 1'b1) begin
        tests_failed++;
        $display("FAIL h1_rotate%0d: got grant=%b sel=%0d valid=%b, required grant=%b sel=%0d valid=1",
                 i, grant1, sel1, valid1, g, owner);
      end else begin
        $display("[TB] h1_rotate%0d grant=%b ok", i, grant1);
      end
    end
    // Only requester 1 left: it wins and keeps the grant without contention.
    req1 = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (grant1 !== 4'b0100 || sel1 !== 2'd1 || mux1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL h1_lone%0d: got grant=%b sel=%0d mux=%b, required grant=0100 sel=1 mux=0",
                 i, grant1, sel1, mux1);
      end else begin
        $display("[TB] h1_lone%0d grant=%b ok", i, grant1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
